// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: access-size encodings, controller
// states and the alignment rule applied to every captured request.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10,
        INIT = 2'b11
    } dmem_state_e;

    // The reserved size encoding is reported as a bad access so one check covers both.
    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the MEM stage (master) and the data memory unit (slave).
interface data_memory_unit_if;

    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        Unsigned;
    logic        Busy;
    logic        Ready;
    logic        Fault;
    logic [31:0] ReadData;

    modport master (
        output Address, WriteData, MemWrite, MemRead, Size, Unsigned,
        input  Busy, Ready, Fault, ReadData
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, Size, Unsigned,
        output Busy, Ready, Fault, ReadData
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: merges store data into the addressed word and
// extracts/extends load data from it. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        zero_ext,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [3:0]  mask;
    logic [31:0] wrep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        mask = 4'b0000;
        wrep = wdata;
        // Replicating the right-justified data lets every lane pick from the same position.
        case (size)
            SIZE_BYTE: begin
                mask = 4'b0001 << lane;
                wrep = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                mask = lane[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
            end
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase

        new_word = old_word;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                new_word[8*k +: 8] = wrep[8*k +: 8];
            end
        end
    end

    always_comb begin
        ld_byte = old_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SIZE_BYTE: load_data = zero_ext ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: load_data = zero_ext ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:   load_data = old_word;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// Word-organised data RAM with byte/half/word access, alignment fault and a LATENCY-cycle
// request/ready handshake. Define DMEM_CLEAR_ON_RESET_EN to zero the RAM after reset.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    data_memory_unit_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [31:0] mem [DEPTH];

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic [31:0]      rdata_q, rdata_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
    logic [AW-1:0]    init_idx_q, init_idx_d;
`endif

    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;

    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          req_wr, req_rd, req_uns, req_fault;
    logic [1:0]    req_size;
    logic          accept, commit;
    logic [31:0]   old_word, new_word, load_data;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^bus.Address[31:AW+2];

    // With single-cycle latency the commit happens on the accept edge, so use live inputs.
    always_comb begin
        if (LATENCY == 1) begin
            req_addr  = bus.Address[AW+1:0];
            req_wdata = bus.WriteData;
            req_wr    = bus.MemWrite;
            req_rd    = bus.MemRead;
            req_size  = bus.Size;
            req_uns   = bus.Unsigned;
        end else begin
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_wr    = wr_q;
            req_rd    = rd_q;
            req_size  = size_q;
            req_uns   = uns_q;
        end
        req_fault = (req_rd && req_wr) || dmem_misaligned(req_size, req_addr[1:0]);
    end

    assign old_word = mem[req_addr[AW+1:2]];

    dmem_lane_align u_align (
        .old_word  (old_word),
        .wdata     (req_wdata),
        .size      (req_size),
        .lane      (req_addr[1:0]),
        .zero_ext  (req_uns),
        .new_word  (new_word),
        .load_data (load_data)
    );

    always_comb begin
        accept  = ((state_q == IDLE) || (state_q == DONE)) && (bus.MemRead || bus.MemWrite);
        commit  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        size_d  = size_q;
        uns_d   = uns_q;
`ifdef DMEM_CLEAR_ON_RESET_EN
        init_idx_d = init_idx_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d  = bus.Address[AW+1:0];
                    wdata_d = bus.WriteData;
                    wr_d    = bus.MemWrite;
                    rd_d    = bus.MemRead;
                    size_d  = bus.Size;
                    uns_d   = bus.Unsigned;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef DMEM_CLEAR_ON_RESET_EN
            INIT: begin
                init_idx_d = init_idx_q + AW'(1);
                if (init_idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (commit) begin
            ready_d = 1'b1;
            fault_d = req_fault;
            if (req_fault) begin
                rdata_d = '0;
            end else if (req_rd) begin
                rdata_d = load_data;
            end
        end

        busy_d = (state_d == WAIT) || (state_d == INIT);
    end

    always_comb begin
        mem_we    = commit && req_wr && !req_fault;
        mem_widx  = req_addr[AW+1:2];
        mem_wdata = new_word;
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (state_q == INIT) begin
            mem_we    = 1'b1;
            mem_widx  = init_idx_q;
            mem_wdata = '0;
        end
`endif
        // A request caught by reset must never reach the array.
        mem_we = mem_we && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
            state_q    <= INIT;
            busy_q     <= 1'b1;
            init_idx_q <= '0;
`else
            state_q    <= IDLE;
            busy_q     <= 1'b0;
`endif
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
            init_idx_q <= init_idx_d;
`endif
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign bus.Busy     = busy_q;
    assign bus.Ready    = ready_q;
    assign bus.Fault    = fault_q;
    assign bus.ReadData = rdata_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: directed and random requests against a byte-array model.
`timescale 1ns/1ps
module tb_data_memory_unit;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int BYTES   = 4 * DEPTH;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    data_memory_unit_if bus();

    data_memory_unit #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        bit          fault;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mbytes [BYTES];
    int         total  = 0;
    int         bad    = 0;
    int         cyc    = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_fault(input bit rd, input bit wr, input logic [1:0] size,
                                       input logic [31:0] addr);
        return (rd && wr) || (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input bit uns);
        int unsigned a = addr & (BYTES - 1);
        int          n = nbytes(size);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size);
        int unsigned a = addr & (BYTES - 1);
        for (int i = 0; i < nbytes(size); i++) mbytes[a + i] = wdata[8*i +: 8];
    endtask

    task automatic drive_idle();
        bus.Address = '0; bus.WriteData = '0; bus.MemWrite = 1'b0;
        bus.MemRead = 1'b0; bus.Size = 2'd0; bus.Unsigned = 1'b0;
    endtask

    task automatic drive_garbage();
        bus.Address   = $urandom;
        bus.WriteData = $urandom;
        bus.MemWrite  = 1'($urandom_range(0, 1));
        bus.MemRead   = 1'($urandom_range(0, 1));
        bus.Size      = 2'($urandom_range(0, 3));
        bus.Unsigned  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_free();
        int n = 0;
        @(negedge clk);
        while (bus.Busy && n < 200) begin
            drive_garbage();
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("busy_release", 32'(bus.Busy), 32'd0);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input bit uns);
        exp_t e;
        wait_free();
        bus.Address = addr; bus.WriteData = wdata; bus.MemWrite = wr;
        bus.MemRead = rd;   bus.Size = size;       bus.Unsigned = uns;
        e.acc   = cyc + 1;
        e.fault = model_fault(rd, wr, size, addr);
        e.chk   = e.fault || rd;
        e.data  = e.fault ? 32'd0 : (rd ? model_load(addr, size, uns) : 32'd0);
        if (!e.fault && wr) model_store(addr, wdata, size);
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        drive_idle();
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_init();
        int n = 0;
        while (bus.Busy && n < 2 * DEPTH + 8) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles", 32'(n), CLEAR_EN ? 32'(DEPTH) : 32'd0);
        if (CLEAR_EN) for (int i = 0; i < BYTES; i++) mbytes[i] = 8'h00;
    endtask

    // Monitor: owns the cycle count and pops the scoreboard on every Ready pulse.
    initial begin
        exp_t h;
        bit   exp_busy;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].acc + LATENCY - 1);
                check("busy", 32'(bus.Busy), 32'(exp_busy));
                if (bus.Ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_ready", 32'(bus.Ready), 32'd0);
                    end else begin
                        h = sb.pop_front();
                        check("latency", 32'(cyc - h.acc), 32'(LATENCY - 1));
                        check("fault", 32'(bus.Fault), 32'(h.fault));
                        if (h.chk) check("rdata", bus.ReadData, h.data);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].acc + LATENCY - 1) begin
                    check("ready_timeout", 32'(bus.Ready), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(bus.Busy),  32'(CLEAR_EN));
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_fault", 32'(bus.Fault), 32'd0);
        check("rst_rdata", bus.ReadData,   32'd0);
        reset = 1'b0;
        wait_init();
        mon_en = 1'b1;

        for (int w = 0; w < DEPTH; w++) begin
            if (CLEAR_EN) issue(1'b1, 1'b0, 32'(w * 4), 32'd0, 2'd2, 1'b0);
            else          issue(1'b0, 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0);
        end

        issue(1'b0, 1'b1, 32'h0,   32'h40,       2'd2, 1'b0);
        issue(1'b1, 1'b0, 32'h0,   32'h0,        2'd2, 1'b0);
        issue(1'b0, 1'b1, 32'h5,   32'h80,       2'd0, 1'b0);
        issue(1'b1, 1'b0, 32'h5,   32'h0,        2'd0, 1'b0);
        issue(1'b1, 1'b0, 32'h5,   32'h0,        2'd0, 1'b1);
        issue(1'b1, 1'b0, 32'h4,   32'h0,        2'd2, 1'b0);
        issue(1'b0, 1'b1, 32'h3,   32'hBEEF,     2'd1, 1'b0);
        issue(1'b1, 1'b0, 32'h0,   32'h0,        2'd2, 1'b0);
        issue(1'b1, 1'b0, 32'h8,   32'h0,        2'd3, 1'b0);
        issue(1'b1, 1'b1, 32'h8,   32'h1234,     2'd2, 1'b0);
        issue(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0);
        issue(1'b1, 1'b0, 32'h0,   32'h0,        2'd2, 1'b0);
        issue(1'b0, 1'b1, 32'h12,  32'h8001,     2'd1, 1'b0);
        issue(1'b1, 1'b0, 32'h12,  32'h0,        2'd1, 1'b0);
        issue(1'b1, 1'b0, 32'h12,  32'h0,        2'd1, 1'b1);
        issue(1'b1, 1'b0, 32'h6,   32'h0,        2'd1, 1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] r;
            logic [1:0]  sz;
            bit          rd;
            bit          wr;
            int          k;
            r  = $urandom;
            k  = $urandom_range(0, 9);
            rd = (k < 5);
            wr = (k >= 4);
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) sz = 2'd3;
            a = (r & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) drain();
        end
        drain();

        // Reset in the middle of a store's wait: the store must not land.
        mon_en = 1'b0;
        @(negedge clk);
        bus.Address = 32'h20; bus.WriteData = 32'hDEAD_BEEF; bus.MemWrite = 1'b1;
        bus.MemRead = 1'b0;   bus.Size = 2'd2;               bus.Unsigned = 1'b0;
        @(negedge clk);
        drive_idle();
        check("pre_rst_busy", 32'(bus.Busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy",  32'(bus.Busy),  32'(CLEAR_EN));
        check("mid_rst_ready", 32'(bus.Ready), 32'd0);
        check("mid_rst_fault", 32'(bus.Fault), 32'd0);
        check("mid_rst_rdata", bus.ReadData,   32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_init();
        mon_en = 1'b1;
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        issue(1'b1, 1'b0, 32'h4,  32'h0, 2'd2, 1'b0);
        if (CLEAR_EN) issue(1'b1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 2'd2, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Parametrised successor to the single-cycle MIPS data memory: word-organised RAM with byte, halfword and word loads and stores.
- Adds sign/zero extension, an alignment fault, and a configurable-latency request/ready handshake so the pipeline can stall on memory.
- Sits between the MEM stage and the data store of the MIPS core.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 4.
- LATENCY, 2, cycles from the accept edge to the Ready cycle; >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- Unsigned  in  1  loads only: 1 zero-extends, 0 sign-extends.
- Busy  out  1  request in flight; requester must stall.
- Ready  out  1  one-cycle completion pulse.
- Fault  out  1  qualifies Ready: request rejected, no access performed.
- ReadData  out  32  load result, valid while Ready=1.

Behaviour:
- Reset (asynchronous): state IDLE, Busy=0, Ready=0, Fault=0, ReadData=0, latency counter=0.
  - Memory contents are untouched by reset.
  - A request in flight when reset asserts is dropped; no write commits.
- States: IDLE, WAIT, DONE.
- Accept: a request is accepted on a rising edge when state is IDLE or DONE and MemRead|MemWrite=1.
  - Address, WriteData, MemWrite, MemRead, Size and Unsigned are captured at the accept edge.
  - Input changes while Busy=1 are ignored.
- After accept:
  - LATENCY=1: go directly to DONE.
  - LATENCY>1: go to WAIT, counter loaded with LATENCY-1; decrement each cycle; enter DONE on the edge where the counter reaches 1.
- DONE lasts exactly one cycle: Ready=1.
  - A new request in DONE is accepted (back-to-back); otherwise return to IDLE.
- Busy=1 only in WAIT.
- Ready=0 and Fault=0 outside DONE. ReadData holds its last value outside DONE.
- Commit point: the RAM read and write happen on the edge entering DONE. A load issued back-to-back after a store to the same word sees the new data.
- Word index = Address[clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Byte lanes are little-endian: lane k occupies bits [8k+7:8k], with k=Address[1:0].
- Stores:
  - Byte writes only lane Address[1:0].
  - Half writes lanes Address[1]*2 and Address[1]*2+1.
  - Word writes all lanes.
  - Other lanes are preserved.
- Loads extract the addressed lane(s) and extend to 32 bits according to Unsigned.
- Fault conditions, evaluated on captured inputs:
  - MemRead and MemWrite both high.
  - Size=11.
  - Half with Address[0]=1.
  - Word with Address[1:0]!=0.
- On Fault: the full latency is still observed, Ready=1 with Fault=1, ReadData=0, and no memory write occurs.

Optional Feature:
- Macro DMEM_CLEAR_ON_RESET_EN.
- Defined: after reset deasserts, an extra INIT state writes zero to word 0..DEPTH-1, one word per cycle.
  - Busy=1 during INIT; requests are ignored.
  - Enter IDLE after DEPTH cycles.
  - Reset during INIT restarts the sweep from word 0.
- Not defined: no INIT state; IDLE immediately after reset; memory initial contents undefined (X in simulation).

Decomposition:
- Package dmem_pkg holds:
  - Size encoding constants SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - The state enum (IDLE, WAIT, DONE, INIT).
  - A misalignment-check function.
- One combinational sub-module, dmem_lane_align, performs store merge (old word + data + lane mask -> new word) and load extract/extend.

Test Plan (DEPTH=256, LATENCY=2):
- Store word 0x40 to addr 0, then load word addr 0 -> Busy=1 one cycle; Ready two cycles after each accept; ReadData=0x00000040, Fault=0.
- Store byte 0x80 to addr 5, then load byte signed and unsigned from addr 5 -> 0xFFFFFF80, then 0x00000080; load word addr 4 shows only lane 1 changed.
- Store half 0xBEEF to addr 3 -> Ready with Fault=1; a following load word addr 0 is unchanged. Size=11, and MemRead=MemWrite=1, also give Fault=1.
- Store word to addr 0x400 (wraps to word 0), then load addr 0 -> data matches (wrap-around).
- Back-to-back: issue a load in the Ready cycle of a store to the same address -> accepted with no idle gap, returns the new data. Changing inputs during Busy has no effect.
- Assert reset during WAIT of a store -> outputs return to reset values immediately; a later load shows the old data. With DMEM_CLEAR_ON_RESET_EN: Busy=1 for 256 cycles after reset, then every word reads 0.
